// File: rtl/ins_loader_if.sv
// ins_loader_if: host byte stream plus instruction BRAM port A write bus
interface ins_loader_if #(
  parameter int AW = 8,
  parameter int DW = 64
);
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          ins_ena;
  logic          ins_wea;
  logic [AW-1:0] ins_addra;
  logic [DW-1:0] ins_dina;
  modport master (output s_data, s_valid, input s_ready, ins_ena, ins_wea, ins_addra, ins_dina);
  modport slave (input s_data, s_valid, output s_ready, ins_ena, ins_wea, ins_addra, ins_dina);
endinterface

// File: rtl/ins_loader.sv
// ins_loader: packs a headed byte stream into instruction words, writes them to BRAM and gates the core reset
module ins_loader #(
  parameter int INS_ADDR_WIDTH = 8,
  parameter int INS_DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    load_req,
  ins_loader_if.slave             bus,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_err,
  output logic [INS_ADDR_WIDTH:0] word_count,
  output logic                    core_rstn
);
  localparam int BYTES_PER_WORD = INS_DATA_WIDTH / 8;
  localparam int BW = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
  typedef enum logic [2:0] {IDLE, HDR, COLLECT, WRITE, DONE} state_t;
  state_t                    state;
  logic [INS_DATA_WIDTH-1:0] shreg;
  logic [INS_ADDR_WIDTH-1:0] last;
  logic [INS_ADDR_WIDTH:0]   widx;
  logic [BW-1:0]             bidx;
  logic [INS_DATA_WIDTH-1:0] nxt;
  logic                      ovf;
  assign nxt = INS_DATA_WIDTH'({shreg, bus.s_data});
  assign ovf = {1'b0, bus.s_data} >= 9'(1 << INS_ADDR_WIDTH);
  // load sequencer: every output is registered and updated on state transitions
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state         <= IDLE;
      bus.s_ready   <= 1'b0;
      bus.ins_ena   <= 1'b0;
      bus.ins_wea   <= 1'b0;
      bus.ins_addra <= '0;
      bus.ins_dina  <= '0;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      word_count    <= '0;
      core_rstn     <= 1'b0;
      shreg         <= '0;
      last          <= '0;
      widx          <= '0;
      bidx          <= '0;
    end else begin
      load_done   <= 1'b0;
      bus.ins_ena <= 1'b0;
      bus.ins_wea <= 1'b0;
      case (state)
        IDLE: if (load_req) begin
          state       <= HDR;
          load_err    <= 1'b0;
          word_count  <= '0;
          core_rstn   <= 1'b0;
          bus.s_ready <= 1'b1;
          busy        <= 1'b1;
        end
        HDR: if (bus.s_valid) begin
          if (ovf) begin
            load_err    <= 1'b1;
            state       <= IDLE;
            bus.s_ready <= 1'b0;
            busy        <= 1'b0;
          end else begin
            last  <= bus.s_data[INS_ADDR_WIDTH-1:0];
            widx  <= '0;
            bidx  <= '0;
            state <= COLLECT;
          end
        end
        COLLECT: if (bus.s_valid) begin
          shreg <= nxt;
          if (bidx == BW'(BYTES_PER_WORD - 1)) begin
            state         <= WRITE;
            bus.s_ready   <= 1'b0;
            bus.ins_ena   <= 1'b1;
            bus.ins_wea   <= 1'b1;
            bus.ins_addra <= widx[INS_ADDR_WIDTH-1:0];
            bus.ins_dina  <= nxt;
          end else
            bidx <= bidx + 1'b1;
        end
        WRITE: begin
          word_count <= word_count + 1'b1;
          if (widx == {1'b0, last}) begin
            state     <= DONE;
            load_done <= 1'b1;
          end else begin
            widx        <= widx + 1'b1;
            bidx        <= '0;
            state       <= COLLECT;
            bus.s_ready <= 1'b1;
          end
        end
        DONE: begin
          core_rstn <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
